// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: iterative shift-add multiplier and restoring divider, STEP bits per cycle.
// Define MULDIV_FAST_MUL_EN to resolve MUL/MULH/MULHSU/MULHU with a single-cycle combinational product.
module ex_muldiv #(
  parameter int XLEN     = 32,
  parameter int STEP     = 1,
  parameter int RegAddrW = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [2:0]          op_i,
  input  logic [XLEN-1:0]     reg1_i,
  input  logic [XLEN-1:0]     reg2_i,
  input  logic [RegAddrW-1:0] wd_i,
  input  logic                wreg_i,
  input  logic                flush_i,
  input  logic                hold_i,
  output logic                ex_stall,
  output logic                done_o,
  output logic [XLEN-1:0]     wdata_o,
  output logic [RegAddrW-1:0] wd_o,
  output logic                wreg_o
);

  localparam int NITER = XLEN / STEP;
  localparam int CNTW  = $clog2(NITER + 1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_n;

  logic [2:0]          op_q;
  logic [RegAddrW-1:0] wd_q;
  logic                wreg_q;
  logic [XLEN-1:0]     hi_q, lo_q, mag2_q;
  logic                neg_q, neg_r_q;
  logic [CNTW-1:0]     cnt_q;

  logic            s1, s2, rs1_neg, rs2_neg;
  logic            div_zero, div_ovf, bypass, accept, last;
  logic [XLEN-1:0] mag1, mag2, bypass_res;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Operand decode: signedness, magnitudes and the cases that skip iteration
  always_comb begin
    s1       = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    s2       = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    rs1_neg  = s1 & reg1_i[XLEN-1];
    rs2_neg  = s2 & reg2_i[XLEN-1];
    mag1     = rs1_neg ? -reg1_i : reg1_i;
    mag2     = rs2_neg ? -reg2_i : reg2_i;
    div_zero = op_i[2] && (reg2_i == '0);
    div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) && (reg1_i == MIN_NEG) && (reg2_i == '1);
    bypass   = div_zero | div_ovf;
    bypass_res = '0;
    if (div_zero)
      bypass_res = op_i[1] ? reg1_i : '1;
    else if (div_ovf)
      bypass_res = op_i[1] ? '0 : reg1_i;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = $signed({{XLEN{rs1_neg}}, reg1_i}) * $signed({{XLEN{rs2_neg}}, reg2_i});
    if (!op_i[2]) begin
      bypass     = 1'b1;
      bypass_res = (op_i == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
    accept = (state == IDLE) && start_i && !flush_i;
    last   = (cnt_q == CNTW'(1));
  end

  logic [XLEN+STEP-1:0] partial, mul_sum;
  logic [XLEN-1:0]      mul_hi, mul_lo;

  // Multiply: add multiplicand times the low STEP multiplier bits, shift the pair right
  always_comb begin
    partial = '0;
    for (int i = 0; i < STEP; i++)
      if (lo_q[i]) partial = partial + ({{STEP{1'b0}}, mag2_q} << i);
    mul_sum = {{STEP{1'b0}}, hi_q} + partial;
    mul_hi  = mul_sum[XLEN+STEP-1:STEP];
    mul_lo  = {mul_sum[STEP-1:0], lo_q[XLEN-1:STEP]};
  end

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] div_r, div_q;

  // Divide: STEP restoring iterations; hi holds the partial remainder, lo shifts dividend out and quotient in
  always_comb begin
    div_r = hi_q;
    div_q = lo_q;
    trial = '0;
    for (int i = 0; i < STEP; i++) begin
      trial = {div_r, div_q[XLEN-1]};
      div_q = {div_q[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, mag2_q}) begin
        trial    = trial - {1'b0, mag2_q};
        div_q[0] = 1'b1;
      end
      div_r = trial[XLEN-1:0];
    end
  end

  logic [XLEN-1:0]   hi_n, lo_n, result;
  logic [2*XLEN-1:0] prod_fix;

  always_comb begin
    hi_n     = op_q[2] ? div_r : mul_hi;
    lo_n     = op_q[2] ? div_q : mul_lo;
    prod_fix = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    case (op_q)
      OP_MUL:                      result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             result = neg_q ? -lo_n : lo_n;
      default:                     result = neg_r_q ? -hi_n : hi_n;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Flush overrides everything, including a held result
  always_comb begin
    state_n  = state;
    ex_stall = 1'b0;
    done_o   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          ex_stall = 1'b1;
          state_n  = bypass ? DONE : CALC;
        end
      end
      CALC: begin
        ex_stall = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done_o   = 1'b1;
        ex_stall = hold_i;
        if (!hold_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush_i) begin
      state_n  = IDLE;
      ex_stall = 1'b0;
      done_o   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      mag2_q  <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      cnt_q   <= '0;
      wdata_o <= '0;
      wd_o    <= '0;
      wreg_o  <= 1'b0;
    end else if (accept) begin
      op_q    <= op_i;
      wd_q    <= wd_i;
      wreg_q  <= wreg_i;
      hi_q    <= '0;
      lo_q    <= mag1;
      mag2_q  <= mag2;
      neg_q   <= rs1_neg ^ rs2_neg;
      neg_r_q <= rs1_neg;
      cnt_q   <= CNTW'(NITER);
      if (bypass) begin
        wdata_o <= bypass_res;
        wd_o    <= wd_i;
        wreg_o  <= wreg_i;
      end
    end else if ((state == CALC) && !flush_i) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q - CNTW'(1);
      if (last) begin
        wdata_o <= result;
        wd_o    <= wd_q;
        wreg_o  <= wreg_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: a STEP=1 instance for most checks plus a STEP=4 instance.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, start4, flush, hold, wreg;
  logic [2:0]  op;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;

  logic        stall1, done1, wreg_o1, stall4, done4, wreg_o4;
  logic [31:0] wdata1, wdata4;
  logic [4:0]  wd_o1, wd_o4;

  bit          use4 = 1'b0;
  logic        obs_stall, obs_done, obs_wreg;
  logic [31:0] obs_wdata;
  logic [4:0]  obs_wd;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  wd;
  } exp_t;
  exp_t sb[$];

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .STEP(1), .RegAddrW(5)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .reg1_i(reg1), .reg2_i(reg2),
    .wd_i(wd), .wreg_i(wreg), .flush_i(flush), .hold_i(hold),
    .ex_stall(stall1), .done_o(done1), .wdata_o(wdata1), .wd_o(wd_o1), .wreg_o(wreg_o1)
  );

  ex_muldiv #(.XLEN(32), .STEP(4), .RegAddrW(5)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .op_i(op), .reg1_i(reg1), .reg2_i(reg2),
    .wd_i(wd), .wreg_i(wreg), .flush_i(flush), .hold_i(hold),
    .ex_stall(stall4), .done_o(done4), .wdata_o(wdata4), .wd_o(wd_o4), .wreg_o(wreg_o4)
  );

  always_comb begin
    obs_stall = use4 ? stall4  : stall1;
    obs_done  = use4 ? done4   : done1;
    obs_wreg  = use4 ? wreg_o4 : wreg_o1;
    obs_wdata = use4 ? wdata4  : wdata1;
    obs_wd    = use4 ? wd_o4   : wd_o1;
  end

  // Reference RV32M semantics built from wide integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb2, ua, ub;
    logic [63:0] p;
    ia = a; ib = b; sa = ia; sb2 = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    p = '0;
    case (f)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sb2; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int niter);
    if (!f[2]) return FastMul ? 1 : niter + 1;
    if (b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return niter + 1;
  endfunction

  task automatic checkVal(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one op for a single cycle; leaves the bench #1 into the first cycle after acceptance
  task automatic driveStart(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    @(negedge clk);
    op = f; reg1 = a; reg2 = b; wd = d; wreg = 1'b1;
    if (use4) start4 = 1'b1;
    else      start  = 1'b1;
    #1;
    checkVal(32'(obs_stall), 32'd1, "accept stall");
    @(negedge clk);
    start = 1'b0; start4 = 1'b0;
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] d, input logic [31:0] exp);
    exp_t e;
    e.data = exp;
    e.wd   = d;
    sb.push_back(e);
    driveStart(f, a, b, d);
  endtask

  task automatic waitDone(output int cyc, output int stall_cnt);
    cyc = 1;
    stall_cnt = 1;
    while (!obs_done && cyc < 100) begin
      if (obs_stall) stall_cnt++;
      @(negedge clk); #1;
      cyc++;
    end
  endtask

  task automatic checkOutput(input int lat, input string tag);
    int cyc, sc;
    exp_t e;
    waitDone(cyc, sc);
    checkVal(32'(obs_done), 32'd1, {tag, " done"});
    checkVal(cyc, lat, {tag, " latency"});
    checkVal(sc, lat, {tag, " stall cycles"});
    tests++;
    assert (sb.size() > 0) else begin
      fails++;
      $error("[TB] FAIL %s scoreboard: observed empty expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkVal(obs_wdata, e.data, {tag, " wdata"});
      checkVal(32'(obs_wd), 32'(e.wd), {tag, " wd"});
    end
    checkVal(32'(obs_wreg), 32'd1, {tag, " wreg"});
    checkVal(32'(obs_stall), 32'd0, {tag, " done stall"});
    @(negedge clk); #1;
    checkVal(32'(obs_done), 32'd0, {tag, " done drop"});
  endtask

  initial begin
    int cyc, sc;
    bit saw_done;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    exp_t e;

    rst = 1'b1; start = 1'b0; start4 = 1'b0; flush = 1'b0; hold = 1'b0;
    wreg = 1'b0; op = '0; reg1 = '0; reg2 = '0; wd = '0;
    repeat (2) @(negedge clk);
    #1;
    checkVal(32'(done1), 32'd0, "reset done");
    checkVal(32'(stall1), 32'd0, "reset stall");
    checkVal(wdata1, 32'd0, "reset wdata");
    checkVal(32'(wd_o1), 32'd0, "reset wd");
    checkVal(32'(wreg_o1), 32'd0, "reset wreg");
    checkVal(32'(done4), 32'd0, "reset done4");
    rst = 1'b0;

    applyStimulus(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
    checkOutput(latency(3'd0, 32'd7, 32'hFFFF_FFFD, 32), "mul");
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    checkOutput(latency(3'd3, '1, '1, 32), "mulhu");
    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000);
    checkOutput(latency(3'd1, '1, '1, 32), "mulh");
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF);
    checkOutput(latency(3'd2, '1, '1, 32), "mulhsu");
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);
    checkOutput(33, "div");
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
    checkOutput(33, "rem");
    applyStimulus(3'd5, 32'h8000_0000, 32'h10, 5'd7, 32'h0800_0000);
    checkOutput(33, "divu");
    applyStimulus(3'd4, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF);
    checkOutput(1, "div by zero");
    applyStimulus(3'd7, 32'd5, 32'd0, 5'd9, 32'd5);
    checkOutput(1, "remu by zero");
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000);
    checkOutput(1, "div overflow");
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0);
    checkOutput(1, "rem overflow");

    // Flush on the tenth cycle of a divide
    saw_done = 1'b0;
    driveStart(3'd5, 32'd100, 32'd7, 5'd30);
    repeat (9) begin
      @(negedge clk); #1;
      if (done1) saw_done = 1'b1;
    end
    flush = 1'b1;
    #1;
    checkVal(32'(stall1), 32'd0, "flush stall");
    checkVal(32'(done1), 32'd0, "flush done");
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkVal(32'(stall1), 32'd0, "flush idle");
    checkVal(32'(saw_done), 32'd0, "flush no done");
    applyStimulus(3'd5, 32'd100, 32'd7, 5'd12, 32'd14);
    checkOutput(33, "after flush");

    // Reset in the middle of an op
    driveStart(3'd0, 32'd7, 32'd3, 5'd13);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal(32'(done1), 32'd0, "midrst done");
    checkVal(32'(stall1), 32'd0, "midrst stall");
    checkVal(wdata1, 32'd0, "midrst wdata");
    checkVal(32'(wd_o1), 32'd0, "midrst wd");
    checkVal(32'(wreg_o1), 32'd0, "midrst wreg");
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      if (done1) saw_done = 1'b1;
    end
    checkVal(32'(saw_done), 32'd0, "midrst no done");

    // Hold the result for four cycles
    applyStimulus(3'd7, 32'd100, 32'd7, 5'd14, 32'd2);
    waitDone(cyc, sc);
    checkVal(32'(done1), 32'd1, "hold done");
    checkVal(cyc, 33, "hold latency");
    e = sb.pop_front();
    hold = 1'b1;
    for (int h = 0; h < 4; h++) begin
      if (h > 0) @(negedge clk);
      #1;
      checkVal(32'(done1), 32'd1, $sformatf("hold%0d done", h));
      checkVal(wdata1, e.data, $sformatf("hold%0d wdata", h));
      checkVal(32'(stall1), 32'd1, $sformatf("hold%0d stall", h));
    end
    @(negedge clk);
    hold = 1'b0;
    #1;
    checkVal(32'(done1), 32'd1, "release done");
    checkVal(32'(stall1), 32'd0, "release stall");
    checkVal(wdata1, e.data, "release wdata");
    @(negedge clk); #1;
    checkVal(32'(done1), 32'd0, "release idle");

    // STEP=4 instance
    use4 = 1'b1;
    applyStimulus(3'd5, 32'd100, 32'd7, 5'd15, 32'd14);
    checkOutput(9, "step4 divu");
    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd16, 32'hFFFF_FFEB);
    checkOutput(latency(3'd0, 32'd7, 32'hFFFF_FFFD, 8), "step4 mul");
    applyStimulus(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd17, 32'hFFFF_FFFE);
    checkOutput(9, "step4 rem");
    use4 = 1'b0;

    for (int k = 0; k < 6; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (k == 2) ? 32'd0 : $urandom;
      applyStimulus(rop, ra, rb, 5'(k + 18), model(rop, ra, rb));
      checkOutput(latency(rop, ra, rb, 32), $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
